// File: rtl/jailbreak_pkg.sv
// Shared types and defaults for the Jailbreak high-score save/restore sequencer.
package jailbreak_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_SAVE,
    ST_RESTORE,
    ST_VERIFY,
    ST_RELEASE
  } hs_seq_state_e;

  typedef enum logic {
    DIR_SAVE,
    DIR_RESTORE
  } hs_dir_e;

  localparam int unsigned HS_HALT_SETTLE_DEFAULT = 16;

endpackage

// File: rtl/jailbreak_hs_seq.sv
// Halts the core and copies high-score bytes between the core port and a buffer RAM.
// Optional read-back check after restore is enabled by defining JAILBREAK_HS_VERIFY_EN.
module jailbreak_hs_seq
  import jailbreak_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned HALT_SETTLE = HS_HALT_SETTLE_DEFAULT,
  parameter int unsigned CORE_RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_save,
  input  logic                  start_restore,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  processor_halt,
  output logic [ADDR_WIDTH-1:0] hs_address,
  output logic [7:0]            hs_data_in,
  input  logic [7:0]            hs_data_out,
  output logic                  hs_write_enable,
  output logic                  hs_access_write,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [7:0]            buf_wr_data,
  output logic                  buf_wr,
  input  logic [7:0]            buf_rd_data
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned SW = $clog2(HALT_SETTLE) + 1;
  localparam int unsigned LW = $clog2(CORE_RD_LAT) + 1;

  hs_seq_state_e         state_q;
  hs_dir_e               dir_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         cnt_q;
  logic [SW-1:0]         settle_q;
  logic [LW-1:0]         lat_q;
  logic                  busy_q, done_q, halt_q;
  logic                  hs_we_q, hs_aw_q, buf_wr_q;
  logic [ADDR_WIDTH-1:0] hs_addr_q, buf_addr_q;
  logic [7:0]            hs_din_q, buf_wdata_q;
`ifdef JAILBREAK_HS_VERIFY_EN
  logic                  err_q;
`endif

  // cnt_q == len_q marks the drain cycle in which the final strobe is visible.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_SAVE;
      len_q       <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      halt_q      <= 1'b0;
      hs_we_q     <= 1'b0;
      hs_aw_q     <= 1'b0;
      buf_wr_q    <= 1'b0;
      hs_addr_q   <= '0;
      buf_addr_q  <= '0;
      hs_din_q    <= '0;
      buf_wdata_q <= '0;
`ifdef JAILBREAK_HS_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      hs_we_q  <= 1'b0;
      buf_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_save || start_restore) begin
            dir_q  <= start_save ? DIR_SAVE : DIR_RESTORE;
            len_q  <= len;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef JAILBREAK_HS_VERIFY_EN
            err_q  <= 1'b0;
`endif
            if (len == '0) begin
              state_q <= ST_RELEASE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_HALT;
              halt_q   <= 1'b1;
              settle_q <= SW'(HALT_SETTLE - 1);
            end
          end
        end
        ST_HALT: begin
          if (settle_q == '0) begin
            lat_q      <= '0;
            hs_addr_q  <= '0;
            buf_addr_q <= '0;
            if (dir_q == DIR_SAVE) begin
              state_q <= ST_SAVE;
            end else begin
              state_q <= ST_RESTORE;
              hs_aw_q <= 1'b1;
            end
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_SAVE: begin
          if (cnt_q == len_q) begin
            state_q <= ST_RELEASE;
            done_q  <= 1'b1;
            halt_q  <= 1'b0;
          end else if (lat_q == LW'(CORE_RD_LAT)) begin
            buf_wr_q    <= 1'b1;
            buf_addr_q  <= hs_addr_q;
            buf_wdata_q <= hs_data_out;
            hs_addr_q   <= ADDR_WIDTH'(cnt_q + CW'(1));
            cnt_q       <= cnt_q + CW'(1);
            lat_q       <= '0;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        ST_RESTORE: begin
          if (cnt_q == len_q) begin
            hs_aw_q <= 1'b0;
`ifdef JAILBREAK_HS_VERIFY_EN
            state_q    <= ST_VERIFY;
            cnt_q      <= '0;
            lat_q      <= '0;
            hs_addr_q  <= '0;
            buf_addr_q <= '0;
`else
            state_q <= ST_RELEASE;
            done_q  <= 1'b1;
            halt_q  <= 1'b0;
`endif
          end else if (lat_q != '0) begin
            // Buffer data for the current address is valid this cycle.
            hs_we_q    <= 1'b1;
            hs_addr_q  <= buf_addr_q;
            hs_din_q   <= buf_rd_data;
            buf_addr_q <= ADDR_WIDTH'(cnt_q + CW'(1));
            cnt_q      <= cnt_q + CW'(1);
            lat_q      <= '0;
          end else begin
            lat_q <= LW'(1);
          end
        end
`ifdef JAILBREAK_HS_VERIFY_EN
        ST_VERIFY: begin
          if (lat_q == LW'(CORE_RD_LAT)) begin
            if (hs_data_out != buf_rd_data) err_q <= 1'b1;
            if (cnt_q == len_q - CW'(1)) begin
              state_q <= ST_RELEASE;
              done_q  <= 1'b1;
              halt_q  <= 1'b0;
            end else begin
              hs_addr_q  <= ADDR_WIDTH'(cnt_q + CW'(1));
              buf_addr_q <= ADDR_WIDTH'(cnt_q + CW'(1));
              cnt_q      <= cnt_q + CW'(1);
              lat_q      <= '0;
            end
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
`endif
        ST_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign processor_halt  = halt_q;
  assign hs_address      = hs_addr_q;
  assign hs_data_in      = hs_din_q;
  assign hs_write_enable = hs_we_q;
  assign hs_access_write = hs_aw_q;
  assign buf_addr        = buf_addr_q;
  assign buf_wr_data     = buf_wdata_q;
  assign buf_wr          = buf_wr_q;
`ifdef JAILBREAK_HS_VERIFY_EN
  assign error           = err_q;
`else
  assign error           = 1'b0;
`endif

endmodule
